vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters, active-low syncs and display
// enable delayed to line up with the pixel mapper, plus a start-of-frame pulse and frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sof,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0]            draw_x_q, draw_x_d;
    logic [9:0]            draw_y_q, draw_y_d;
    logic                  sof_q, sof_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [SYNC_DELAY-1:0] blank_pipe_q, blank_pipe_d;
    logic                  line_end, frame_end;
    logic                  hs_raw, vs_raw, blank_raw;

    always_comb begin
        line_end      = (draw_x_q == H_LAST);
        frame_end     = line_end && (draw_y_q == V_LAST);

        draw_x_d      = line_end ? 10'd0 : draw_x_q + 10'd1;
        draw_y_d      = draw_y_q;
        if (line_end) begin
            draw_y_d = (draw_y_q == V_LAST) ? 10'd0 : draw_y_q + 10'd1;
        end

        // sof registers the wrap itself, so the post-reset 0,0 state never pulses
        sof_d         = frame_end;
        frame_count_d = frame_end ? frame_count_q + 16'd1 : frame_count_q;

        hs_raw        = ~((draw_x_q >= H_SYNC_START) && (draw_x_q <= H_SYNC_END));
        vs_raw        = ~((draw_y_q >= V_SYNC_START) && (draw_y_q <= V_SYNC_END));
        blank_raw     = (draw_x_q < H_VIS) && (draw_y_q < V_VIS);

        hs_pipe_d       = hs_pipe_q;
        vs_pipe_d       = vs_pipe_q;
        blank_pipe_d    = blank_pipe_q;
        hs_pipe_d[0]    = hs_raw;
        vs_pipe_d[0]    = vs_raw;
        blank_pipe_d[0] = blank_raw;
        for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_d[i]    = hs_pipe_q[i-1];
            vs_pipe_d[i]    = vs_pipe_q[i-1];
            blank_pipe_d[i] = blank_pipe_q[i-1];
        end
    end

    // Delay lines reset to the inactive levels so no stale pulse leaks out after reset
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            sof_q         <= 1'b0;
            frame_count_q <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            blank_pipe_q  <= '0;
        end else begin
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            sof_q         <= sof_d;
            frame_count_q <= frame_count_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            blank_pipe_q  <= blank_pipe_d;
        end
    end

    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign sof         = sof_q;
    assign frame_count = frame_count_q;
    assign hs          = hs_pipe_q[SYNC_DELAY-1];
    assign vs          = vs_pipe_q[SYNC_DELAY-1];
    assign blank       = blank_pipe_q[SYNC_DELAY-1];

endmodule
